// File: rtl/dec_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : dec_sched_if
// Purpose  : Source-side and engine-side signal bundle for dec_sched.
// Revision : 1.0
// ============================================================================
interface dec_sched_if #(
    parameter int D_WIDTH = 8
);
    logic [1:0]         alg_i;
    logic [D_WIDTH-1:0] data_i;
    logic               valid_i;
    logic               ready_o;

    logic [D_WIDTH-1:0] data0_o;
    logic [D_WIDTH-1:0] data1_o;
    logic [D_WIDTH-1:0] data2_o;
    logic               valid0_o;
    logic               valid1_o;
    logic               valid2_o;
    logic               busy0_i;
    logic               busy1_i;
    logic               busy2_i;

    logic [1:0]         sel_o;
    logic               msg_done_o;
    logic               err_o;

    modport slave (
        input  alg_i, data_i, valid_i, busy0_i, busy1_i, busy2_i,
        output ready_o, data0_o, data1_o, data2_o, valid0_o, valid1_o, valid2_o,
        output sel_o, msg_done_o, err_o
    );

    modport master (
        output alg_i, data_i, valid_i, busy0_i, busy1_i, busy2_i,
        input  ready_o, data0_o, data1_o, data2_o, valid0_o, valid1_o, valid2_o,
        input  sel_o, msg_done_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/dec_sched.sv
`default_nettype none
// ============================================================================
// Module   : dec_sched
// Purpose  : Routes encrypted messages to one of three decryption engines and
//            tracks each message until the engine has finished with it.
// Revision : 1.0
// ============================================================================
module dec_sched #(
    parameter int                 D_WIDTH = 8,
    parameter logic [D_WIDTH-1:0] TERM    = 8'hFA,
    parameter int                 MAX_LEN = 50,
    parameter int                 TO_CYC  = 16
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    dec_sched_if.slave ifc
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_DONE      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    localparam logic [5:0] C_LAST_CNT = 6'(MAX_LEN - 1);
    localparam logic [7:0] C_TO_LIMIT = 8'(TO_CYC);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [1:0]               r_sel;
    logic [5:0]               r_char_cnt;
    logic [7:0]               r_to_cnt;
    logic                     r_done;
    logic                     r_err;
    logic [2:0]               r_valid;
    logic [2:0][D_WIDTH-1:0]  r_data;

    logic                     w_xfer;
    logic                     w_fwd;
    logic                     w_illegal;
    logic [1:0]               w_fwd_sel;
    logic [2:0]               w_hit;
    logic                     w_busy_sel;

    assign ifc.ready_o = rst_n && ((r_state == S_IDLE) || (r_state == S_LOAD));
    assign w_xfer      = ifc.valid_i && ifc.ready_o;

    // The first character of a message picks the engine; later ones follow r_sel.
    assign w_fwd_sel = (r_state == S_IDLE) ? ifc.alg_i : r_sel;
    assign w_hit     = w_fwd ? (3'b001 << w_fwd_sel) : 3'b000;

    always_comb begin
        case (r_sel)
            2'd0:    w_busy_sel = ifc.busy0_i;
            2'd1:    w_busy_sel = ifc.busy1_i;
            default: w_busy_sel = ifc.busy2_i;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_fwd        = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (ifc.alg_i == 2'd3) begin
                        w_illegal = 1'b1;
                    end else begin
                        w_fwd        = 1'b1;
                        w_next_state = (ifc.data_i == TERM) ? S_WAIT_BUSY : S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_fwd = 1'b1;
                    if (ifc.data_i == TERM) begin
                        w_next_state = S_WAIT_BUSY;
                    end else if (r_char_cnt == C_LAST_CNT) begin
                        w_next_state = S_ERR;
                    end
                end
            end
            S_WAIT_BUSY: begin
                if (w_busy_sel) begin
                    w_next_state = S_WAIT_IDLE;
                end else if (r_to_cnt == C_TO_LIMIT) begin
                    w_next_state = S_ERR;
                end
            end
            S_WAIT_IDLE: begin
                if (!w_busy_sel) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sel      <= 2'd0;
            r_char_cnt <= 6'd0;
            r_to_cnt   <= 8'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_valid    <= 3'b000;
            r_data     <= '0;
        end else begin
            r_state <= w_next_state;
            // Pulses are registered so they coincide with the DONE/ERR state cycle.
            r_done  <= (w_next_state == S_DONE);
            r_err   <= (w_next_state == S_ERR) || w_illegal;

            if (w_fwd && (r_state == S_IDLE)) begin
                r_sel      <= ifc.alg_i;
                r_char_cnt <= 6'd1;
            end else if (w_fwd) begin
                r_char_cnt <= r_char_cnt + 6'd1;
            end

            if (r_state != S_WAIT_BUSY) begin
                r_to_cnt <= 8'd0;
            end else if (r_to_cnt != C_TO_LIMIT) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end

            for (int n = 0; n < 3; n++) begin
                r_valid[n] <= w_hit[n];
                r_data[n]  <= w_hit[n] ? ifc.data_i : '0;
            end
        end
    end

    assign ifc.sel_o      = r_sel;
    assign ifc.msg_done_o = r_done;
    assign ifc.err_o      = r_err;
    assign ifc.valid0_o   = r_valid[0];
    assign ifc.valid1_o   = r_valid[1];
    assign ifc.valid2_o   = r_valid[2];
    assign ifc.data0_o    = r_data[0];
    assign ifc.data1_o    = r_data[1];
    assign ifc.data2_o    = r_data[2];

endmodule
`default_nettype wire

// File: doc/dec_sched.md
DEC_SCHED -- requirements
Module: dec_sched

Interface
REQ-001 Parameter D_WIDTH, default 8: character width in bits.
REQ-002 Parameter TERM, default 8'hFA: end-of-message character.
REQ-003 Parameter MAX_LEN, default 50: maximum number of characters per message, TERM included; legal range 2..63.
REQ-004 Parameter TO_CYC, default 16: maximum number of cycles to wait for engine busy to rise; legal range 1..255.
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 alg_i  in  2  requested algorithm (0 Caesar, 1 Scytale, 2 ZigZag, 3 illegal); sampled only on the first character of a message.
REQ-008 data_i  in  D_WIDTH  encrypted character from the source.
REQ-009 valid_i  in  1  data_i qualifier; a character transfers on a cycle where valid_i=1 and ready_o=1.
REQ-010 ready_o  out  1  scheduler can accept a character this cycle.
REQ-011 dataN_o / validN_o, N=0..2  out  D_WIDTH / 1  character and strobe to decryption engine N.
REQ-012 busyN_i, N=0..2  in  1  engine N is processing a message.
REQ-013 sel_o  out  2  output-mux select; identifies the engine that owns the current or most recent message.
REQ-014 msg_done_o  out  1  one-cycle pulse when a message has been fully decrypted.
REQ-015 err_o  out  1  one-cycle pulse on a protocol error.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, LOAD, WAIT_BUSY, WAIT_IDLE, DONE, ERR.
REQ-017 ready_o SHALL be a decode of the registered state: 1 in IDLE and LOAD, 0 in every other state.
REQ-018 IDLE, transfer with alg_i<3: sel_o<=alg_i, char_cnt<=1, forward the character, go to LOAD; if that character equals TERM, go to WAIT_BUSY instead.
REQ-019 IDLE, transfer with alg_i=3: drop the character, pulse err_o next cycle, remain in IDLE, leave sel_o unchanged.
REQ-020 Forwarding SHALL take one cycle: the cycle after a transfer, data{sel}_o=data_i and valid{sel}_o=1.
REQ-021 The strobes of the two non-selected engines SHALL stay 0, and every data port whose strobe is 0 SHALL be driven to 0.
REQ-022 LOAD: alg_i is ignored; each transfer is forwarded per REQ-020 and increments char_cnt.
REQ-023 LOAD, transferred character equals TERM: forward it and go to WAIT_BUSY.
REQ-024 LOAD, non-TERM transfer with char_cnt=MAX_LEN-1: forward it, then go to ERR.
REQ-025 WAIT_BUSY: a timeout counter is cleared on entry; busy{sel}_i=1 goes to WAIT_IDLE; otherwise, once the counter reaches TO_CYC, go to ERR.
REQ-026 WAIT_IDLE: busy{sel}_i=0 goes to DONE; there is no timeout in this state.
REQ-027 DONE: msg_done_o=1 for exactly this one cycle, then go to IDLE.
REQ-028 ERR: err_o=1 for exactly this one cycle, then go to IDLE (the pulse of REQ-019 is generated identically).
REQ-029 sel_o SHALL change only as described in REQ-018 and SHALL hold its value through DONE, ERR and the following IDLE.
REQ-030 The busyN_i inputs of non-selected engines SHALL be ignored.
REQ-031 char_cnt SHALL be 6 bits and the timeout counter 8 bits; neither counter wraps, because each terminates at its limit.
REQ-032 A character presented while ready_o=0 is not consumed; the source holds it until ready_o returns to 1.

Reset
REQ-033 With rst_n=0 at a rising edge: state<=IDLE; sel_o, all dataN_o, all validN_o, msg_done_o, err_o, char_cnt and the timeout counter <= 0.
REQ-034 While rst_n=0, ready_o=0.
REQ-035 Reset asserted mid-message aborts the message: no msg_done_o or err_o pulse is produced, and no partial strobe is emitted afterwards.

Verification
REQ-036 Nominal message: alg_i=1, chars 41,42,FA back-to-back, busy1_i high 3 cycles from 2 cycles after FA -> valid1_o for 3 consecutive cycles carrying 41,42,FA; sel_o=1; one msg_done_o pulse; valid0_o=valid2_o=0 throughout.
REQ-037 Illegal algorithm: alg_i=3, char 55 -> no validN_o; err_o pulse 1 cycle after the transfer; ready_o stays 1.
REQ-038 Length overflow: MAX_LEN=4, alg_i=0, five non-TERM chars offered -> exactly 4 forwarded on valid0_o; err_o pulses; fifth char not accepted until back in IDLE.
REQ-039 Busy timeout: message 30,FA on alg_i=2, busy2_i held 0 -> err_o pulses TO_CYC+1 cycles after entering WAIT_BUSY; no msg_done_o.
REQ-040 Reset mid-LOAD: rst_n=0 after 2 chars -> next cycle all outputs 0 and ready_o=0; after release, ready_o=1 and a new message uses the new alg_i.
REQ-041 Single-char message: alg_i=0, first char FA -> FSM goes IDLE->WAIT_BUSY; with busy0_i pulsed, msg_done_o pulses once.
